chip_mem_xfer: RTL and testbench

- Block-transfer engine between the CHIP-8 register file V0..VF and one port of the 4096x8 chip RAM.
- Executes the memory-side work of FX55 (store V0..VX at I), FX65 (load V0..VX from I) and FX33 (BCD of VX at I, I+1, I+2).
- It is the initiator on the RAM port. That port has a 1-cycle registered read latency and write-first behaviour.
- The core's instruction FSM issues one command and waits for done.

---
 rtl/chip_mem_xfer.sv | 159 +++++++++++++++
 tb/tb_chip_mem_xfer.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/chip_mem_xfer.sv
// CHIP-8 block-transfer engine: FX55 store, FX65 load and FX33 BCD between V0..VF and chip RAM.
// Optional CHIP8_I_INCR_EN: on store/load completion, pulse i_we with i_new = I + x + 1.
module chip_mem_xfer #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 8,
  parameter int REG_AW = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [REG_AW-1:0] x,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [REG_AW-1:0] reg_raddr,
  input  logic [DATA_W-1:0] reg_rdata,
  output logic [REG_AW-1:0] reg_waddr,
  output logic [DATA_W-1:0] reg_wdata,
  output logic              reg_we,
  output logic [ADDR_W-1:0] i_new,
  output logic              i_we
);

  typedef enum logic [2:0] {IDLE, STORE, LOAD, BCD_RD, BCD_WR, DONE} state_t;

  state_t              state;
  logic [REG_AW-1:0]   x_q;
  logic [ADDR_W-1:0]   i_q;
  logic [REG_AW:0]     n;
  logic [DATA_W-1:0]   hund, tens, ones;
  logic [DATA_W-1:0]   d_h, d_t, d_o;
  logic [31:0]         v;
  logic [REG_AW:0]     x_ext;
  logic [ADDR_W-1:0]   addr_n;
`ifdef CHIP8_I_INCR_EN
  logic                rw_cmd;
`endif

  assign x_ext  = {1'b0, x_q};
  assign addr_n = i_q + ADDR_W'(n);

  always_comb begin
    v   = 32'(reg_rdata);
    d_h = DATA_W'(v / 32'd100);
    d_t = DATA_W'((v / 32'd10) % 32'd10);
    d_o = DATA_W'(v % 32'd10);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      x_q   <= '0;
      i_q   <= '0;
      n     <= '0;
      hund  <= '0;
      tens  <= '0;
      ones  <= '0;
`ifdef CHIP8_I_INCR_EN
      rw_cmd <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (start) begin
          x_q <= x;
          i_q <= i_addr;
          n   <= '0;
`ifdef CHIP8_I_INCR_EN
          rw_cmd <= ~op[1];
`endif
          case (op)
            2'b00:   state <= STORE;
            2'b01:   state <= LOAD;
            2'b10:   state <= BCD_RD;
            default: state <= DONE;
          endcase
        end
        STORE: begin
          if (n == x_ext) state <= DONE;
          else n <= n + 1'b1;
        end
        LOAD: begin
          // one extra cycle to catch the read data of the last address
          if (n == x_ext + 1'b1) state <= DONE;
          else n <= n + 1'b1;
        end
        BCD_RD: begin
          hund  <= d_h;
          tens  <= d_t;
          ones  <= d_o;
          n     <= '0;
          state <= BCD_WR;
        end
        BCD_WR: begin
          if (n == (REG_AW+1)'(2)) state <= DONE;
          else n <= n + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    busy      = 1'b0;
    done      = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    reg_raddr = '0;
    reg_waddr = '0;
    reg_wdata = '0;
    reg_we    = 1'b0;
    i_new     = '0;
    i_we      = 1'b0;
    case (state)
      STORE: begin
        busy      = 1'b1;
        reg_raddr = n[REG_AW-1:0];
        mem_addr  = addr_n;
        mem_wdata = reg_rdata;
        mem_we    = 1'b1;
      end
      LOAD: begin
        busy = 1'b1;
        if (n <= x_ext) mem_addr = addr_n;
        if (n != '0) begin
          reg_we    = 1'b1;
          reg_waddr = REG_AW'(n - 1'b1);
          reg_wdata = mem_rdata;
        end
      end
      BCD_RD: begin
        busy      = 1'b1;
        reg_raddr = x_q;
      end
      BCD_WR: begin
        busy      = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = addr_n;
        mem_wdata = (n == '0) ? hund : (n == (REG_AW+1)'(1)) ? tens : ones;
      end
      DONE: begin
        done = 1'b1;
`ifdef CHIP8_I_INCR_EN
        if (rw_cmd) begin
          i_we  = 1'b1;
          i_new = i_q + ADDR_W'(x_q) + ADDR_W'(1);
        end
`endif
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_chip_mem_xfer.sv
// Bench for chip_mem_xfer: RAM/register-file environment, per-cycle expectation queue from a command model.
module tb_chip_mem_xfer;
  logic        clk = 0, reset_n = 0, start = 0;
  logic [1:0]  op = 0;
  logic [3:0]  x = 0;
  logic [11:0] i_addr = 0;
  logic        busy, done, mem_we, reg_we, i_we;
  logic [11:0] mem_addr, i_new;
  logic [7:0]  mem_wdata, mem_rdata, reg_rdata, reg_wdata;
  logic [3:0]  reg_raddr, reg_waddr;

  logic [7:0]  ram [4096];
  logic [7:0]  rf  [16];
  logic [7:0]  mram[4096];
  logic [7:0]  mrf [16];
  logic        pk_m = 0, pk_r = 0;
  logic [11:0] pk_a = 0;
  logic [7:0]  pk_d = 0;
  int          errors = 0, checks = 0, we_cnt = 0;

  typedef struct packed {
    bit busy, done, mwe, achk, rwe, iwe;
    bit [11:0] maddr;
    bit [7:0]  mwd;
    bit [3:0]  rwa;
    bit [7:0]  rwd;
    bit [11:0] inew;
  } exp_t;
  exp_t q[$];

  chip_mem_xfer dut (
    .clk(clk), .reset_n(reset_n), .start(start), .op(op), .x(x), .i_addr(i_addr),
    .busy(busy), .done(done), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rdata(mem_rdata), .reg_raddr(reg_raddr), .reg_rdata(reg_rdata),
    .reg_waddr(reg_waddr), .reg_wdata(reg_wdata), .reg_we(reg_we), .i_new(i_new), .i_we(i_we)
  );

  always #5 clk = ~clk;

  // write-first RAM with registered read, combinational-read register file
  assign reg_rdata = rf[reg_raddr];
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    else if (pk_m) ram[pk_a] <= pk_d;
    mem_rdata <= mem_we ? mem_wdata : ram[mem_addr];
    if (reg_we) rf[reg_waddr] <= reg_wdata;
    else if (pk_r) rf[pk_a[3:0]] <= pk_d;
  end

  task automatic chk(input string nm, input int a, input int b);
    checks++;
    if (a != b) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, a, b, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!reset_n) begin
      chk("rst_busy", busy, 0);  chk("rst_done", done, 0);
      chk("rst_mem_we", mem_we, 0); chk("rst_reg_we", reg_we, 0); chk("rst_i_we", i_we, 0);
      chk("rst_mem_addr", mem_addr, 0); chk("rst_mem_wdata", mem_wdata, 0);
      chk("rst_reg_waddr", reg_waddr, 0); chk("rst_reg_wdata", reg_wdata, 0);
      chk("rst_reg_raddr", reg_raddr, 0); chk("rst_i_new", i_new, 0);
    end else begin
      e = '0;
      if (q.size() != 0) e = q.pop_front();
      chk("busy", busy, e.busy); chk("done", done, e.done);
      chk("mem_we", mem_we, e.mwe); chk("reg_we", reg_we, e.rwe); chk("i_we", i_we, e.iwe);
      if (e.achk) chk("mem_addr", mem_addr, e.maddr);
      if (e.mwe) begin chk("mem_wdata", mem_wdata, e.mwd); mram[e.maddr] = e.mwd; end
      if (e.rwe) begin
        chk("reg_waddr", reg_waddr, e.rwa); chk("reg_wdata", reg_wdata, e.rwd);
        mrf[e.rwa] = e.rwd;
      end
      if (e.iwe) chk("i_new", i_new, e.inew);
`ifndef CHIP8_I_INCR_EN
      chk("i_new_tied", i_new, 0);
`endif
      if (reg_we) we_cnt++;
    end
  end

  task automatic poke(input bit is_reg, input int a, input logic [7:0] d);
    pk_m = !is_reg; pk_r = is_reg; pk_a = 12'(a); pk_d = d;
    if (is_reg) mrf[a[3:0]] = d; else mram[a[11:0]] = d;
    @(posedge clk); #1;
    pk_m = 0; pk_r = 0;
  endtask

  // expected cycle-by-cycle behaviour of one command, from its architectural effect
  task automatic build(input bit [1:0] o, input bit [3:0] xx, input bit [11:0] ii, output int c);
    exp_t e;
    logic [7:0] v;
    c = 0;
    q.push_back('0);
    case (o)
      2'd0: for (int n = 0; n <= int'(xx); n++) begin
        e = '0; e.busy = 1; e.mwe = 1; e.achk = 1;
        e.maddr = ii + 12'(n); e.mwd = mrf[n];
        q.push_back(e); c++;
      end
      2'd1: for (int n = 0; n <= int'(xx) + 1; n++) begin
        e = '0; e.busy = 1;
        if (n <= int'(xx)) begin e.achk = 1; e.maddr = ii + 12'(n); end
        if (n >= 1) begin e.rwe = 1; e.rwa = 4'(n - 1); e.rwd = mram[ii + 12'(n - 1)]; end
        q.push_back(e); c++;
      end
      2'd2: begin
        v = mrf[xx];
        e = '0; e.busy = 1; q.push_back(e); c++;
        for (int k = 0; k < 3; k++) begin
          e = '0; e.busy = 1; e.mwe = 1; e.achk = 1; e.maddr = ii + 12'(k);
          e.mwd = (k == 0) ? v / 100 : (k == 1) ? (v / 10) % 10 : v % 10;
          q.push_back(e); c++;
        end
      end
      default: ;
    endcase
    e = '0; e.done = 1;
`ifdef CHIP8_I_INCR_EN
    if (o < 2) begin e.iwe = 1; e.inew = ii + 12'(xx) + 12'd1; end
`endif
    q.push_back(e); c++;
  endtask

  task automatic run(input bit [1:0] o, input bit [3:0] xx, input bit [11:0] ii,
                     input bit hold, output int c);
    int t;
    @(posedge clk); #1;
    build(o, xx, ii, c);
    start = 1; op = o; x = xx; i_addr = ii;
    @(posedge clk); #1;
    // keep start high with garbage through every busy cycle and the DONE cycle
    if (hold) for (int j = 0; j < c; j++) begin
      op = 2'($urandom); x = 4'($urandom); i_addr = 12'($urandom);
      @(posedge clk); #1;
    end
    start = 0;
    t = 0;
    while (q.size() != 0 && t < 200) begin @(negedge clk); t++; end
    chk("drain", q.size(), 0);
  endtask

  initial begin
    int c, mism;
    @(posedge clk); #1;
    for (int a = 0; a < 4096; a++) poke(0, a, 8'($urandom));
    for (int a = 0; a < 16; a++) poke(1, a, 8'($urandom));
    reset_n = 1;
    repeat (2) @(posedge clk);

    for (int a = 0; a < 4; a++) poke(1, a, 8'(8'h11 * (a + 1)));
    run(0, 3, 12'h300, 0, c);
    chk("store_cycles", c, 5);
    chk("store_300", ram[12'h300], 8'h11); chk("store_301", ram[12'h301], 8'h22);
    chk("store_302", ram[12'h302], 8'h33); chk("store_303", ram[12'h303], 8'h44);

    poke(0, 12'h400, 8'hA0); poke(0, 12'h401, 8'hB1); poke(0, 12'h402, 8'hC2);
    we_cnt = 0;
    run(1, 2, 12'h400, 0, c);
    chk("load_v0", rf[0], 8'hA0); chk("load_v1", rf[1], 8'hB1); chk("load_v2", rf[2], 8'hC2);
    chk("load_v3", rf[3], 8'h44); chk("load_we_cycles", we_cnt, 3);

    poke(1, 5, 8'hFE);
    run(2, 5, 12'h500, 1, c);
    chk("bcd_500", ram[12'h500], 2); chk("bcd_501", ram[12'h501], 5); chk("bcd_502", ram[12'h502], 4);
    poke(1, 5, 8'h00);
    run(2, 5, 12'h510, 0, c);
    chk("bcd0_510", ram[12'h510], 0); chk("bcd0_511", ram[12'h511], 0); chk("bcd0_512", ram[12'h512], 0);

    run(0, 3, 12'hFFE, 1, c);
    chk("wrap_ffe", ram[12'hFFE], 8'hA0); chk("wrap_fff", ram[12'hFFF], 8'hB1);
    chk("wrap_000", ram[12'h000], 8'hC2); chk("wrap_001", ram[12'h001], 8'h44);

    run(3, 7, 12'h123, 1, c);
    chk("nop_cycles", c, 1);

    for (int it = 0; it < 60; it++) begin
      if ($urandom_range(0, 3) == 0) poke($urandom_range(0, 1) == 1, int'($urandom_range(0, 4095)), 8'($urandom));
      run(2'($urandom), 4'($urandom), 12'($urandom), 1'($urandom), c);
    end

    // reset in the middle of a 16-register load
    @(posedge clk); #1;
    build(1, 15, 12'h100, c);
    start = 1; op = 1; x = 15; i_addr = 12'h100;
    we_cnt = 0;
    @(posedge clk); #1;
    start = 0;
    repeat (5) @(posedge clk);
    #1 reset_n = 0;
    #1;
    chk("abort_busy", busy, 0); chk("abort_reg_we", reg_we, 0);
    q.delete();
    repeat (2) @(posedge clk);
    #1 reset_n = 1;
    chk("abort_we_cycles", we_cnt, 4);

    run(0, 2, 12'h050, 0, c);

    mism = 0;
    for (int a = 0; a < 4096; a++) if (ram[a] !== mram[a]) mism++;
    chk("ram_final", mism, 0);
    mism = 0;
    for (int a = 0; a < 16; a++) if (rf[a] !== mrf[a]) mism++;
    chk("rf_final", mism, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
